// File: rtl/ecc_core_arbiter_if.sv
// Operand, response and core-side bus of the shared ECC point-multiplication core.
// The arbiter takes the slave view; requesters and the core take the master view.
interface ecc_core_arbiter_if #(
    parameter int NUM_REQ  = 4,
    parameter int MAX_BITS = 128
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ-1:0]          req_ready;
    logic [2*NUM_REQ-1:0]        req_mode;
    logic [MAX_BITS*NUM_REQ-1:0] req_a;
    logic [MAX_BITS*NUM_REQ-1:0] req_prime;
    logic [MAX_BITS*NUM_REQ-1:0] req_px;
    logic [MAX_BITS*NUM_REQ-1:0] req_py;
    logic [MAX_BITS*NUM_REQ-1:0] req_mul;

    logic                        rsp_valid;
    logic                        rsp_ready;
    logic [ID_W-1:0]             rsp_id;
    logic [MAX_BITS-1:0]         rsp_x;
    logic [MAX_BITS-1:0]         rsp_y;
    logic                        rsp_err;

    logic                        core_valid;
    logic [1:0]                  core_mode;
    logic [MAX_BITS-1:0]         core_a;
    logic [MAX_BITS-1:0]         core_prime;
    logic [MAX_BITS-1:0]         core_px;
    logic [MAX_BITS-1:0]         core_py;
    logic [MAX_BITS-1:0]         core_mul;
    logic [MAX_BITS-1:0]         core_outx;
    logic [MAX_BITS-1:0]         core_outy;
    logic                        core_finished;

    modport slave (
        input  req_valid, req_mode, req_a, req_prime, req_px, req_py, req_mul,
        input  rsp_ready, core_outx, core_outy, core_finished,
        output req_ready, rsp_valid, rsp_id, rsp_x, rsp_y, rsp_err,
        output core_valid, core_mode, core_a, core_prime, core_px, core_py, core_mul
    );

    modport master (
        output req_valid, req_mode, req_a, req_prime, req_px, req_py, req_mul,
        output rsp_ready, core_outx, core_outy, core_finished,
        input  req_ready, rsp_valid, rsp_id, rsp_x, rsp_y, rsp_err,
        input  core_valid, core_mode, core_a, core_prime, core_px, core_py, core_mul
    );
endinterface

// File: rtl/ecc_core_arbiter.sv
// Round-robin arbiter sharing one ECC point-multiplication core among NUM_REQ requesters.
// Optional watchdog abort of a stuck core: define ECC_ARB_TIMEOUT_EN.
`ifndef BITS16
`define BITS16 2'b00
`endif
`ifndef BITS32
`define BITS32 2'b01
`endif
`ifndef BITS64
`define BITS64 2'b10
`endif
`ifndef BITS128
`define BITS128 2'b11
`endif

module ecc_core_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int MAX_BITS       = 128,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic              clk,
    input  logic              rst,
    ecc_core_arbiter_if.slave bus
);
    localparam int ID_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [ID_W-1:0]     grant_s;
    logic                grant_vld_s;
    logic                accept_s;
    logic                expire_s;
    logic [1:0]          gmode_s;
    logic [MAX_BITS-1:0] mask_s;
    logic [1:0]          mode_q, mode_d;
    logic [MAX_BITS-1:0] a_q, a_d, prime_q, prime_d, px_q, px_d, py_q, py_d, mul_q, mul_d;
    logic [MAX_BITS-1:0] x_q, x_d, y_q, y_d;
    logic                err_q, err_d;

    // Keeps only the operand bits that lie below the selected mode width.
    function automatic logic [MAX_BITS-1:0] mode_mask(input logic [1:0] mode);
        int                  width;
        logic [MAX_BITS-1:0] m;
        case (mode)
            `BITS16: width = 16;
            `BITS32: width = 32;
            `BITS64: width = 64;
            default: width = 128;
        endcase
        m = '0;
        for (int i = 0; i < MAX_BITS; i++) begin
            m[i] = (i < width);
        end
        return m;
    endfunction

`ifdef ECC_ARB_TIMEOUT_EN
    logic [31:0] cnt_q, cnt_d;

    // Watchdog counter: zero outside RUN so it restarts on every RUN entry.
    always_comb begin
        cnt_d = 32'd0;
        if (state_q == RUN) begin
            cnt_d = cnt_q + 32'd1;
        end else begin
            cnt_d = 32'd0;
        end
    end

    // Watchdog counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_s = (state_q == RUN) && (cnt_q == 32'(TIMEOUT_CYCLES - 1));
`else
    assign expire_s = 1'b0;
`endif

    // Round-robin search; scanning backwards lets the nearest requester to rr_ptr win.
    always_comb begin
        grant_vld_s = 1'b0;
        grant_s     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (bus.req_valid[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
                grant_vld_s = 1'b1;
                grant_s     = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            end else begin
                grant_vld_s = grant_vld_s;
            end
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        id_d     = id_q;
        mode_d   = mode_q;
        a_d      = a_q;
        prime_d  = prime_q;
        px_d     = px_q;
        py_d     = py_q;
        mul_d    = mul_q;
        x_d      = x_q;
        y_d      = y_q;
        err_d    = err_q;
        accept_s = 1'b0;
        gmode_s  = bus.req_mode[int'(grant_s) * 2 +: 2];
        mask_s   = mode_mask(gmode_s);
        case (state_q)
            IDLE: begin
                if (grant_vld_s) begin
                    accept_s = 1'b1;
                    id_d     = grant_s;
                    rr_ptr_d = ID_W'((int'(grant_s) + 1) % NUM_REQ);
                    mode_d   = gmode_s;
                    a_d      = bus.req_a[int'(grant_s) * MAX_BITS +: MAX_BITS] & mask_s;
                    prime_d  = bus.req_prime[int'(grant_s) * MAX_BITS +: MAX_BITS] & mask_s;
                    px_d     = bus.req_px[int'(grant_s) * MAX_BITS +: MAX_BITS] & mask_s;
                    py_d     = bus.req_py[int'(grant_s) * MAX_BITS +: MAX_BITS] & mask_s;
                    mul_d    = bus.req_mul[int'(grant_s) * MAX_BITS +: MAX_BITS] & mask_s;
                    state_d  = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                // A finish on the expiry cycle still delivers the real result.
                if (bus.core_finished) begin
                    x_d     = bus.core_outx;
                    y_d     = bus.core_outy;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (expire_s) begin
                    x_d     = '0;
                    y_d     = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    state_d = RUN;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, pointer, operand and result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            id_q     <= '0;
            mode_q   <= `BITS32;
            a_q      <= '0;
            prime_q  <= '0;
            px_q     <= '0;
            py_q     <= '0;
            mul_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            mode_q   <= mode_d;
            a_q      <= a_d;
            prime_q  <= prime_d;
            px_q     <= px_d;
            py_q     <= py_d;
            mul_q    <= mul_d;
            x_q      <= x_d;
            y_q      <= y_d;
            err_q    <= err_d;
        end
    end

    assign bus.req_ready  = accept_s ? (NUM_REQ'(1) << grant_s) : '0;
    assign bus.core_valid = (state_q == RUN) & ~bus.core_finished;
    assign bus.core_mode  = mode_q;
    assign bus.core_a     = a_q;
    assign bus.core_prime = prime_q;
    assign bus.core_px    = px_q;
    assign bus.core_py    = py_q;
    assign bus.core_mul   = mul_q;
    assign bus.rsp_valid  = (state_q == RESP);
    assign bus.rsp_id     = id_q;
    assign bus.rsp_x      = x_q;
    assign bus.rsp_y      = y_q;
    assign bus.rsp_err    = err_q;
endmodule

// File: tb/tb_ecc_core_arbiter.sv
// Scoreboard bench for ecc_core_arbiter with a behavioural core (x = px+1, y = py^mul).
// Timeout scenarios run only when ECC_ARB_TIMEOUT_EN is defined.
`ifndef BITS16
`define BITS16 2'b00
`endif
`ifndef BITS32
`define BITS32 2'b01
`endif
`ifndef BITS64
`define BITS64 2'b10
`endif
`ifndef BITS128
`define BITS128 2'b11
`endif

module tb_ecc_core_arbiter;
    localparam int NUM_REQ  = 4;
    localparam int MAX_BITS = 128;

    typedef struct {
        logic [1:0]   id;
        logic [127:0] x;
        logic [127:0] y;
        logic         err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   acc_cnt = 0;
    int   core_lat = 10;
    int   core_cnt = 0;
    bit   core_hang = 1'b0;
    bit   prev_fin = 1'b0;
    exp_t exp_q[$];

    logic [1:0]   ops_mode [NUM_REQ];
    logic [127:0] ops_a    [NUM_REQ];
    logic [127:0] ops_px   [NUM_REQ];
    logic [127:0] ops_py   [NUM_REQ];
    logic [127:0] ops_mul  [NUM_REQ];

    always #5 clk = ~clk;

    ecc_core_arbiter_if #(.NUM_REQ(NUM_REQ), .MAX_BITS(MAX_BITS)) bus ();

    ecc_core_arbiter #(
        .NUM_REQ(NUM_REQ), .MAX_BITS(MAX_BITS), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] mask_of(input logic [1:0] mode);
        case (mode)
            `BITS16: return {112'd0, 16'hFFFF};
            `BITS32: return {96'd0, 32'hFFFF_FFFF};
            `BITS64: return {64'd0, {64{1'b1}}};
            default: return {128{1'b1}};
        endcase
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int i, input logic [1:0] mode, input logic [127:0] px);
        ops_mode[i] = mode;
        ops_a[i]    = rand128();
        ops_px[i]   = px;
        ops_py[i]   = rand128();
        ops_mul[i]  = rand128();
        bus.req_mode[2*i +: 2]    = mode;
        bus.req_a[i*128 +: 128]   = ops_a[i];
        bus.req_prime[i*128 +: 128] = rand128();
        bus.req_px[i*128 +: 128]  = px;
        bus.req_py[i*128 +: 128]  = ops_py[i];
        bus.req_mul[i*128 +: 128] = ops_mul[i];
    endtask

    task automatic push_exp(input int i);
        logic [127:0] m;
        m = mask_of(ops_mode[i]);
        exp_q.push_back('{id: 2'(i), x: (ops_px[i] & m) + 128'd1,
                          y: (ops_py[i] & m) ^ (ops_mul[i] & m), err: 1'b0});
    endtask

    task automatic wait_drain(input int max_cycles);
        for (int c = 0; c < max_cycles && (exp_q.size() != 0 || bus.rsp_valid); c++) begin
            tick();
        end
        check_eq("drain_left", 128'(exp_q.size()), 128'd0);
    endtask

    // Behavioural core: counts held-valid cycles, then pulses finished with its result.
    initial begin
        logic cv;
        bus.core_finished = 1'b0;
        bus.core_outx = '0;
        bus.core_outy = '0;
        forever begin
            tick();
            cv = bus.core_valid;
            bus.core_finished = 1'b0;
            if (cv) begin
                core_cnt++;
                if (!core_hang && core_cnt >= core_lat) begin
                    bus.core_finished = 1'b1;
                    bus.core_outx = bus.core_px + 128'd1;
                    bus.core_outy = bus.core_py ^ bus.core_mul;
                    core_cnt = 0;
                end
            end else begin
                core_cnt = 0;
            end
        end
    end

    // Monitor: counts accepts, scores responses, checks finish-to-response latency.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (|(bus.req_valid & bus.req_ready)) acc_cnt++;
            if (prev_fin) check_eq("rsp_latency", 128'(bus.rsp_valid), 128'd1);
            prev_fin = bus.core_finished;
            if (bus.rsp_valid && bus.rsp_ready) begin
                check_eq("rsp_expected", 128'(exp_q.size() != 0), 128'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_eq("rsp_id", 128'(bus.rsp_id), 128'(e.id));
                    check_eq("rsp_x", bus.rsp_x, e.x);
                    check_eq("rsp_y", bus.rsp_y, e.y);
                    check_eq("rsp_err", 128'(bus.rsp_err), 128'(e.err));
                end
            end
        end else begin
            prev_fin = 1'b0;
        end
    end

    initial begin
        int base;
        int n;
        logic [127:0] ex;
        bus.req_valid = '0;
        bus.req_mode  = '0;
        bus.req_a     = '0;
        bus.req_prime = '0;
        bus.req_px    = '0;
        bus.req_py    = '0;
        bus.req_mul   = '0;
        bus.rsp_ready = 1'b0;
        repeat (2) tick();

        check_eq("rst_rsp_valid", 128'(bus.rsp_valid), 128'd0);
        check_eq("rst_req_ready", 128'(bus.req_ready), 128'd0);
        check_eq("rst_core_valid", 128'(bus.core_valid), 128'd0);
        check_eq("rst_core_mode", 128'(bus.core_mode), 128'(`BITS32));
        check_eq("rst_rsp_x", bus.rsp_x, 128'd0);
        check_eq("rst_rsp_id", 128'(bus.rsp_id), 128'd0);
        check_eq("rst_rsp_err", 128'(bus.rsp_err), 128'd0);
        check_eq("rst_core_px", bus.core_px, 128'd0);
        rst = 1'b1;
        tick();

        // Round robin with all requesters held: 0,1,2,3,0.
        for (int i = 0; i < NUM_REQ; i++) set_ops(i, `BITS128, rand128());
        push_exp(0); push_exp(1); push_exp(2); push_exp(3); push_exp(0);
        bus.rsp_ready = 1'b1;
        base = acc_cnt;
        bus.req_valid = 4'b1111;
        for (int c = 0; c < 400 && acc_cnt < base + 5; c++) tick();
        bus.req_valid = 4'b0000;
        check_eq("rr_accepts", 128'(acc_cnt - base), 128'd5);
        wait_drain(200);

        // Single 16-bit request from requester 2 with a bit above the mode width.
        set_ops(2, `BITS16, 128'h1_ABCD);
        push_exp(2);
        bus.req_valid = 4'b0100;
        #1;
        check_eq("t1_req_ready", 128'(bus.req_ready), 128'h4);
        tick();
        bus.req_valid = 4'b0000;
        check_eq("t1_core_valid", 128'(bus.core_valid), 128'd1);
        check_eq("t1_core_px", bus.core_px, 128'hABCD);
        check_eq("t1_core_a", bus.core_a, ops_a[2] & mask_of(`BITS16));
        check_eq("t1_core_mode", 128'(bus.core_mode), 128'(`BITS16));
        wait_drain(100);

        // Response backpressure with requester 1 waiting.
        set_ops(0, `BITS64, rand128());
        push_exp(0);
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'b0001;
        tick();
        set_ops(1, `BITS32, rand128());
        push_exp(1);
        bus.req_valid = 4'b0010;
        for (int c = 0; c < 100 && !bus.rsp_valid; c++) tick();
        ex = exp_q[0].x;
        for (int c = 0; c < 20; c++) begin
            check_eq("bp_rsp_valid", 128'(bus.rsp_valid), 128'd1);
            check_eq("bp_rsp_id", 128'(bus.rsp_id), 128'd0);
            check_eq("bp_rsp_x", bus.rsp_x, ex);
            check_eq("bp_req_ready", 128'(bus.req_ready), 128'd0);
            tick();
        end
        bus.rsp_ready = 1'b1;
        tick();
        check_eq("bp_next_grant", 128'(bus.req_ready), 128'h2);
        tick();
        bus.req_valid = 4'b0000;
        wait_drain(100);

        // Reset five cycles into RUN; the job is lost and the pointer restarts at 0.
        core_lat = 100;
        set_ops(1, `BITS128, rand128());
        bus.req_valid = 4'b0010;
        tick();
        bus.req_valid = 4'b0000;
        repeat (5) tick();
        check_eq("r4_core_valid_run", 128'(bus.core_valid), 128'd1);
        rst = 1'b0;
        #1;
        check_eq("r4_core_valid_rst", 128'(bus.core_valid), 128'd0);
        check_eq("r4_rsp_valid_rst", 128'(bus.rsp_valid), 128'd0);
        repeat (2) tick();
        rst = 1'b1;
        core_lat = 10;
        set_ops(0, `BITS32, rand128());
        push_exp(0);
        bus.req_valid = 4'b1101;
        #1;
        check_eq("r4_grant_after_rst", 128'(bus.req_ready), 128'h1);
        tick();
        bus.req_valid = 4'b0000;
        wait_drain(100);

`ifdef ECC_ARB_TIMEOUT_EN
        // Core never finishes: watchdog aborts after 16 RUN cycles.
        core_hang = 1'b1;
        set_ops(3, `BITS128, rand128());
        exp_q.push_back('{id: 2'd3, x: 128'd0, y: 128'd0, err: 1'b1});
        bus.req_valid = 4'b1000;
        tick();
        bus.req_valid = 4'b0000;
        n = 0;
        for (int c = 0; c < 100 && bus.core_valid; c++) begin
            n++;
            tick();
        end
        check_eq("to_run_cycles", 128'(n), 128'd16);
        check_eq("to_rsp_valid", 128'(bus.rsp_valid), 128'd1);
        check_eq("to_rsp_err", 128'(bus.rsp_err), 128'd1);
        check_eq("to_rsp_x", bus.rsp_x, 128'd0);
        check_eq("to_rsp_y", bus.rsp_y, 128'd0);
        core_hang = 1'b0;
        wait_drain(50);

        // Finish lands on the expiry cycle: the real result wins.
        core_lat = 16;
        set_ops(1, `BITS64, rand128());
        push_exp(1);
        bus.req_valid = 4'b0010;
        tick();
        bus.req_valid = 4'b0000;
        wait_drain(100);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
